// File: rtl/nn_pkg.sv
// Shared constants for the network weight-load path: unit geometry, per-layer
// RAM stride and the state codes of the layer sequencer and RAM read driver.
package nn_pkg;

    localparam int NUM_UNITS        = 4;
    localparam int WEIGHTS_PER_UNIT = 4;
    localparam int LAYER_STRIDE     = NUM_UNITS * WEIGHTS_PER_UNIT;

    localparam logic [1:0] SEQ_IDLE        = 2'd0;
    localparam logic [1:0] SEQ_START_LAYER = 2'd1;
    localparam logic [1:0] SEQ_WAIT_DONE   = 2'd2;
    localparam logic [1:0] SEQ_FINISH      = 2'd3;

    localparam logic [1:0] DRV_IDLE  = 2'd0;
    localparam logic [1:0] DRV_READ  = 2'd1;
    localparam logic [1:0] DRV_FLUSH = 2'd2;
    localparam logic [1:0] DRV_TRIG  = 2'd3;

endpackage

// File: rtl/ram_weight_mux.sv
// Registered demultiplexer steering RAM read data into one of four per-unit
// weight registers, with a one-cycle write strobe for the selected unit.
module ram_weight_mux #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_i,
    input  logic [1:0]        unitSel_i,
    input  logic [DATA_W-1:0] ramData_i,
    output logic [DATA_W-1:0] weight0_o,
    output logic [DATA_W-1:0] weight1_o,
    output logic [DATA_W-1:0] weight2_o,
    output logic [DATA_W-1:0] weight3_o,
    output logic [3:0]        writeVec_o
);

    logic [DATA_W-1:0] weight_q [4];
    logic [3:0]        writeVec_q;

    // Weights hold between loads; only the addressed unit sees a strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                weight_q[i] <= '0;
            end
            writeVec_q <= '0;
        end else begin
            writeVec_q <= write_i ? (4'b0001 << unitSel_i) : 4'b0000;
            if (write_i) begin
                weight_q[unitSel_i] <= ramData_i;
            end
        end
    end

    assign weight0_o  = weight_q[0];
    assign weight1_o  = weight_q[1];
    assign weight2_o  = weight_q[2];
    assign weight3_o  = weight_q[3];
    assign writeVec_o = writeVec_q;

endmodule

// File: rtl/network_ram_controller.sv
// Layer sequencer, weight-RAM read driver and unit demux for a 3-layer network.
// Define RAM_OUT_REG_EN for a RAM with a 2-cycle (output-registered) read latency.
module network_ram_controller #(
    parameter int NUM_LAYERS = 3,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              done,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W-1:0] RAM_address,
    output logic [1:0]        layer,
    output logic              layer_sel,
    output logic              RAM_Controll_Start,
    output logic [1:0]        unit_sel,
    output logic [1:0]        unit_address,
    output logic              write,
    output logic              sum_trigger,
    output logic [DATA_W-1:0] weight0,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] weight3,
    output logic              write0,
    output logic              write1,
    output logic              write2,
    output logic              write3,
    output logic              network_done
);

    import nn_pkg::*;

    localparam int LOADS = NUM_UNITS * WEIGHTS_PER_UNIT;
`ifdef RAM_OUT_REG_EN
    localparam logic FLUSH_LAST = 1'b1;
`else
    localparam logic FLUSH_LAST = 1'b0;
`endif

    logic [1:0]        seqState_q, seqState_d;
    logic [1:0]        layer_q, layer_d;
    logic [1:0]        drvState_q, drvState_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flush_q, flush_d;
    logic [4:0]        rdTag1_q;
    logic [4:0]        rdTag;
    logic [3:0]        writeVec;

    // done is only honoured once the driver has finished loading the layer.
    always_comb begin
        seqState_d = seqState_q;
        layer_d    = layer_q;
        case (seqState_q)
            SEQ_IDLE: begin
                if (start) begin
                    layer_d    = 2'd0;
                    seqState_d = SEQ_START_LAYER;
                end
            end
            SEQ_START_LAYER: seqState_d = SEQ_WAIT_DONE;
            SEQ_WAIT_DONE: begin
                if (done && drvState_q == DRV_IDLE) begin
                    if (layer_q < 2'(NUM_LAYERS - 1)) begin
                        layer_d    = layer_q + 2'd1;
                        seqState_d = SEQ_START_LAYER;
                    end else begin
                        seqState_d = SEQ_FINISH;
                    end
                end
            end
            SEQ_FINISH: seqState_d = SEQ_IDLE;
            default:    seqState_d = SEQ_IDLE;
        endcase
    end

    always_comb begin
        drvState_d = drvState_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        flush_d    = flush_q;
        case (drvState_q)
            DRV_IDLE: begin
                if (RAM_Controll_Start) begin
                    drvState_d = DRV_READ;
                    cnt_d      = 4'd0;
                    addr_d     = ADDR_W'(layer_q) * ADDR_W'(LAYER_STRIDE);
                end
            end
            DRV_READ: begin
                if (cnt_q == 4'(LOADS - 1)) begin
                    drvState_d = DRV_FLUSH;
                    flush_d    = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRV_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    drvState_d = DRV_TRIG;
                end else begin
                    flush_d = 1'b1;
                end
            end
            DRV_TRIG: drvState_d = DRV_IDLE;
            default:  drvState_d = DRV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seqState_q <= SEQ_IDLE;
            layer_q    <= 2'd0;
            drvState_q <= DRV_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            flush_q    <= 1'b0;
            rdTag1_q   <= 5'd0;
        end else begin
            seqState_q <= seqState_d;
            layer_q    <= layer_d;
            drvState_q <= drvState_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            flush_q    <= flush_d;
            rdTag1_q   <= {drvState_q == DRV_READ, cnt_q};
        end
    end

    // The {valid, unit, idx} tag follows the RAM pipeline so it lines up with ram_out.
`ifdef RAM_OUT_REG_EN
    logic [4:0] rdTag2_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdTag2_q <= 5'd0;
        end else begin
            rdTag2_q <= rdTag1_q;
        end
    end
    assign rdTag = rdTag2_q;
`else
    assign rdTag = rdTag1_q;
`endif

    assign write        = rdTag[4];
    assign unit_sel     = rdTag[3:2];
    assign unit_address = rdTag[1:0];

    assign RAM_address        = addr_q;
    assign layer              = layer_q;
    assign layer_sel          = |layer_q;
    assign RAM_Controll_Start = (seqState_q == SEQ_START_LAYER);
    assign network_done       = (seqState_q == SEQ_FINISH);
    assign sum_trigger        = (drvState_q == DRV_TRIG);

    ram_weight_mux #(
        .DATA_W(DATA_W)
    ) u_mux (
        .clk       (clk),
        .reset     (reset),
        .write_i   (write),
        .unitSel_i (unit_sel),
        .ramData_i (ram_out),
        .weight0_o (weight0),
        .weight1_o (weight1),
        .weight2_o (weight2),
        .weight3_o (weight3),
        .writeVec_o(writeVec)
    );

    assign write0 = writeVec[0];
    assign write1 = writeVec[1];
    assign write2 = writeVec[2];
    assign write3 = writeVec[3];

endmodule

// File: tb/tb_network_ram_controller.sv
// Directed bench for network_ram_controller: a RAM whose contents equal their
// address feeds the controller through all three layers, with disturbances and resets.
module tb_network_ram_controller;

`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic [7:0] ram_out;
    logic [9:0] RAM_address;
    logic [1:0] layer;
    logic       layer_sel;
    logic       RAM_Controll_Start;
    logic [1:0] unit_sel;
    logic [1:0] unit_address;
    logic       write;
    logic       sum_trigger;
    logic [7:0] weight0, weight1, weight2, weight3;
    logic       write0, write1, write2, write3;
    logic       network_done;

    logic [7:0] ramStage1 = 8'd0;
    logic [7:0] ramStage2 = 8'd0;

    int vectors = 0;
    int miscompares = 0;

    network_ram_controller dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .done              (done),
        .ram_out           (ram_out),
        .RAM_address       (RAM_address),
        .layer             (layer),
        .layer_sel         (layer_sel),
        .RAM_Controll_Start(RAM_Controll_Start),
        .unit_sel          (unit_sel),
        .unit_address      (unit_address),
        .write             (write),
        .sum_trigger       (sum_trigger),
        .weight0           (weight0),
        .weight1           (weight1),
        .weight2           (weight2),
        .weight3           (weight3),
        .write0            (write0),
        .write1            (write1),
        .write2            (write2),
        .write3            (write3),
        .network_done      (network_done)
    );

    always #5 clk = ~clk;

    // RAM model: every location holds its own address (low 8 bits).
    always @(posedge clk) begin
        ramStage1 <= RAM_address[7:0];
        ramStage2 <= ramStage1;
    end
    assign ram_out = (LAT == 2) ? ramStage2 : ramStage1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives start/done for exactly one rising edge; entered and left on a negedge.
    task automatic applyStimulus(input logic s, input logic d);
        start = s;
        done  = d;
        @(negedge clk);
        start = 1'b0;
        done  = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " RAM_address"}, 32'(RAM_address), 32'd0);
        checkOutput({tag, " layer"}, 32'(layer), 32'd0);
        checkOutput({tag, " layer_sel"}, 32'(layer_sel), 32'd0);
        checkOutput({tag, " RAM_Controll_Start"}, 32'(RAM_Controll_Start), 32'd0);
        checkOutput({tag, " write/unit"}, 32'({write, unit_sel, unit_address}), 32'd0);
        checkOutput({tag, " sum_trigger"}, 32'(sum_trigger), 32'd0);
        checkOutput({tag, " network_done"}, 32'(network_done), 32'd0);
        checkOutput({tag, " writeN"}, 32'({write3, write2, write1, write0}), 32'd0);
        checkOutput({tag, " weights"}, {weight3, weight2, weight1, weight0}, 32'd0);
    endtask

    task automatic checkLayerStart(input int lyr);
        checkOutput("layer start RAM_Controll_Start", 32'(RAM_Controll_Start), 32'd1);
        checkOutput("layer start layer", 32'(layer), 32'(lyr));
        checkOutput("layer start layer_sel", 32'(layer_sel), (lyr == 0) ? 32'd0 : 32'd1);
    endtask

    // Entered on the negedge where RAM_Controll_Start is high; t counts negedges after it.
    task automatic runLayer(input int lyr, input bit disturb);
        int base = lyr * 16;
        logic [7:0] w [4];
        for (int t = 1; t <= 18 + LAT; t++) begin
            if (disturb && t == 5) done = 1'b1;
            if (disturb && t == 8) start = 1'b1;
            @(negedge clk);
            done  = 1'b0;
            start = 1'b0;
            w[0] = weight0; w[1] = weight1; w[2] = weight2; w[3] = weight3;
            checkOutput($sformatf("L%0d t%0d RAM_address", lyr, t), 32'(RAM_address),
                        (t <= 16) ? 32'(base + t - 1) : 32'(base + 15));
            checkOutput($sformatf("L%0d t%0d layer", lyr, t), 32'(layer), 32'(lyr));
            checkOutput($sformatf("L%0d t%0d RAM_Controll_Start", lyr, t), 32'(RAM_Controll_Start), 32'd0);
            checkOutput($sformatf("L%0d t%0d network_done", lyr, t), 32'(network_done), 32'd0);
            checkOutput($sformatf("L%0d t%0d sum_trigger", lyr, t), 32'(sum_trigger),
                        (t == 17 + LAT) ? 32'd1 : 32'd0);
            if (t >= 1 + LAT && t <= 16 + LAT) begin
                checkOutput($sformatf("L%0d t%0d write", lyr, t), 32'(write), 32'd1);
                checkOutput($sformatf("L%0d t%0d unit_sel", lyr, t), 32'(unit_sel), 32'((t - 1 - LAT) / 4));
                checkOutput($sformatf("L%0d t%0d unit_address", lyr, t), 32'(unit_address), 32'((t - 1 - LAT) % 4));
            end else begin
                checkOutput($sformatf("L%0d t%0d write", lyr, t), 32'(write), 32'd0);
            end
            if (t >= 2 + LAT && t <= 17 + LAT) begin
                checkOutput($sformatf("L%0d t%0d writeN", lyr, t), 32'({write3, write2, write1, write0}),
                            32'(1 << ((t - 2 - LAT) / 4)));
                checkOutput($sformatf("L%0d t%0d weight", lyr, t), 32'(w[(t - 2 - LAT) / 4]),
                            32'(base + t - 2 - LAT));
            end else begin
                checkOutput($sformatf("L%0d t%0d writeN", lyr, t), 32'({write3, write2, write1, write0}), 32'd0);
            end
        end
        checkOutput($sformatf("L%0d final weights", lyr), {weight3, weight2, weight1, weight0},
                    {8'(base + 15), 8'(base + 11), 8'(base + 7), 8'(base + 3)});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
        checkOutput("idle sum_trigger", 32'(sum_trigger), 32'd0);
        checkOutput("idle RAM_Controll_Start", 32'(RAM_Controll_Start), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("in reset");
        reset = 1'b1;
        @(negedge clk);
        checkResetState("after reset");

        applyStimulus(1'b1, 1'b0);
        checkLayerStart(0);
        runLayer(0, 1'b1);

        for (int lyr = 1; lyr < 3; lyr++) begin
            idleCycles(20);
            applyStimulus(1'b0, 1'b1);
            checkLayerStart(lyr);
            runLayer(lyr, 1'b0);
        end

        idleCycles(20);
        applyStimulus(1'b0, 1'b1);
        checkOutput("finish network_done", 32'(network_done), 32'd1);
        checkOutput("finish layer", 32'(layer), 32'd2);
        @(negedge clk);
        checkOutput("after finish network_done", 32'(network_done), 32'd0);
        checkOutput("after finish layer", 32'(layer), 32'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("post-run RAM_Controll_Start", 32'(RAM_Controll_Start), 32'd0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("idle done RAM_Controll_Start", 32'(RAM_Controll_Start), 32'd0);
        checkOutput("idle done layer", 32'(layer), 32'd2);
        checkOutput("idle done network_done", 32'(network_done), 32'd0);

        applyStimulus(1'b1, 1'b0);
        checkLayerStart(0);
        runLayer(0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b0, 1'b1);
        checkLayerStart(1);
        repeat (6) @(negedge clk);
        checkOutput("mid-read layer 1 address", 32'(RAM_address), 32'd21);
        reset = 1'b0;
        #1;
        checkResetState("mid-read reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        checkLayerStart(0);
        runLayer(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
